// File: rtl/frame_sequencer.sv
// Frame sequencer: streams one frame into the detection pipeline, flushes it,
// then walks the object table and returns each centroid on a valid/ready stream.
module frame_sequencer #(
    parameter int LOC_SIZE     = 16,
    parameter int WORD_SIZE    = 8,
    parameter int FLUSH_CYCLES = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [LOC_SIZE-1:0]  width,
    input  logic [LOC_SIZE-1:0]  height,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    output logic                 en,
    output logic [LOC_SIZE-1:0]  x,
    output logic [LOC_SIZE-1:0]  y,
    output logic [LOC_SIZE-1:0]  frame,
    input  logic [WORD_SIZE-1:0] num_labels,
    output logic [WORD_SIZE-1:0] obj_id,
    input  logic [LOC_SIZE-1:0]  obj_x,
    input  logic [LOC_SIZE-1:0]  obj_y,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [WORD_SIZE-1:0] res_id,
    output logic [LOC_SIZE-1:0]  res_x,
    output logic [LOC_SIZE-1:0]  res_y,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        IDLE,
        STREAM,
        FLUSH,
        SCAN_WAIT,
        EMIT,
        DONE
    } state_t;

    localparam logic [LOC_SIZE-1:0]  LOC_ONE    = 1;
    localparam logic [WORD_SIZE-1:0] WORD_ONE   = 1;
    localparam logic [7:0]           FLUSH_LAST = 8'(FLUSH_CYCLES - 1);
    localparam logic [3:0]           LAT_LAST   = 4'(READ_LATENCY - 1);

    state_t state;
    state_t state_nx;

    logic [LOC_SIZE-1:0]  w_r;
    logic [LOC_SIZE-1:0]  h_r;
    logic [WORD_SIZE-1:0] labels_r;
    logic [7:0]           flush_cnt;
    logic [3:0]           lat_cnt;

    logic xfer;
    logic x_last;
    logic y_last;
    logic flush_end;
    logic lat_end;
    logic start_empty;

    assign xfer        = (state == STREAM) && pix_valid;
    assign x_last      = (x == w_r - LOC_ONE);
    assign y_last      = (y == h_r - LOC_ONE);
    assign flush_end   = (flush_cnt == FLUSH_LAST);
    assign lat_end     = (lat_cnt == LAT_LAST);
    assign start_empty = (width == '0) || (height == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = start_empty ? DONE : STREAM;
                end
            end
            STREAM: begin
                if (xfer && x_last && y_last) begin
                    state_nx = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_end) begin
                    state_nx = (num_labels == '0) ? DONE : SCAN_WAIT;
                end
            end
            SCAN_WAIT: begin
                if (lat_end) begin
                    state_nx = EMIT;
                end
            end
            EMIT: begin
                if (res_ready) begin
                    state_nx = (obj_id == labels_r) ? DONE : SCAN_WAIT;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        en        = 1'b0;
        pix_ready = 1'b0;
        res_valid = 1'b0;
        done      = 1'b0;
        busy      = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
            end
            STREAM: begin
                pix_ready = 1'b1;
                en        = pix_valid;
            end
            FLUSH: begin
                en = 1'b1;
            end
            EMIT: begin
                res_valid = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    // Datapath: coordinates, counters, object walk and result capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_r       <= '0;
            h_r       <= '0;
            x         <= '0;
            y         <= '0;
            frame     <= '0;
            labels_r  <= '0;
            obj_id    <= '0;
            res_id    <= '0;
            res_x     <= '0;
            res_y     <= '0;
            flush_cnt <= '0;
            lat_cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        w_r <= width;
                        h_r <= height;
                        if (!start_empty) begin
                            x <= '0;
                            y <= '0;
                        end
                    end
                    flush_cnt <= '0;
                end
                STREAM: begin
                    flush_cnt <= '0;
                    if (xfer) begin
                        if (!x_last) begin
                            x <= x + LOC_ONE;
                        end else if (!y_last) begin
                            x <= '0;
                            y <= y + LOC_ONE;
                        end
                    end
                end
                FLUSH: begin
                    flush_cnt <= flush_cnt + 8'd1;
                    if (flush_end) begin
                        frame    <= frame + LOC_ONE;
                        labels_r <= num_labels;
                        if (num_labels != '0) begin
                            obj_id  <= WORD_ONE;
                            lat_cnt <= '0;
                        end
                    end
                end
                SCAN_WAIT: begin
                    lat_cnt <= lat_cnt + 4'd1;
                    if (lat_end) begin
                        res_id <= obj_id;
                        res_x  <= obj_x;
                        res_y  <= obj_y;
                    end
                end
                EMIT: begin
                    // Stop at labels_r so a full 2^WORD_SIZE-1 table never wraps
                    if (res_ready && (obj_id != labels_r)) begin
                        obj_id  <= obj_id + WORD_ONE;
                        lat_cnt <= '0;
                    end
                end
                DONE: begin
                    flush_cnt <= '0;
                end
                default: begin
                    flush_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer with a small object-table model that
// returns centroids one cycle after obj_id is registered.
module tb_frame_sequencer;

    localparam int LS = 16;
    localparam int WS = 8;
    localparam int RL = 2;

    logic          clk        = 1'b0;
    logic          reset_n    = 1'b1;
    logic          start      = 1'b0;
    logic [LS-1:0] width      = '0;
    logic [LS-1:0] height     = '0;
    logic          pix_valid  = 1'b0;
    logic [WS-1:0] num_labels = '0;
    logic          res_ready  = 1'b0;
    logic [WS-1:0] id_d       = '0;

    logic          pix_ready;
    logic          en;
    logic          busy;
    logic          done;
    logic          res_valid;
    logic [LS-1:0] x;
    logic [LS-1:0] y;
    logic [LS-1:0] frame;
    logic [LS-1:0] obj_x;
    logic [LS-1:0] obj_y;
    logic [LS-1:0] res_x;
    logic [LS-1:0] res_y;
    logic [WS-1:0] obj_id;
    logic [WS-1:0] res_id;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    frame_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .width      (width),
        .height     (height),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .en         (en),
        .x          (x),
        .y          (y),
        .frame      (frame),
        .num_labels (num_labels),
        .obj_id     (obj_id),
        .obj_x      (obj_x),
        .obj_y      (obj_y),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_id     (res_id),
        .res_x      (res_x),
        .res_y      (res_y),
        .busy       (busy),
        .done       (done)
    );

    // Object table: data for an id is readable READ_LATENCY cycles after it is set
    always @(posedge clk) id_d <= obj_id;
    assign obj_x = 16'h0100 + {8'h00, id_d} * 16'd5;
    assign obj_y = 16'h0200 + {8'h00, id_d} * 16'd7;

    function automatic logic [LS-1:0] ex(input int k);
        return LS'(32'h100 + 5 * k);
    endfunction

    function automatic logic [LS-1:0] ey(input int k);
        return LS'(32'h200 + 7 * k);
    endfunction

    int            cyc      = 0;
    int            en_cnt   = 0;
    int            done_cnt = 0;
    int            rv_cnt   = 0;
    int            last_en  = 0;
    int            done_at  = 0;
    logic [LS-1:0] cx[$];
    logic [LS-1:0] cy[$];
    logic [WS-1:0] rid[$];
    logic [LS-1:0] rx[$];
    logic [LS-1:0] ry[$];
    int            hs_at[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (en) begin
            en_cnt  <= en_cnt + 1;
            last_en <= cyc;
        end
        if (en && pix_ready) begin
            cx.push_back(x);
            cy.push_back(y);
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_at  <= cyc;
        end
        if (res_valid) rv_cnt <= rv_cnt + 1;
        if (res_valid && res_ready) begin
            rid.push_back(res_id);
            rx.push_back(res_x);
            ry.push_back(res_y);
            hs_at.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n = 0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(done), 64'd1);
    endtask

    task automatic wait_rv(input string tag, input int limit);
        int n = 0;
        while (!res_valid && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(res_valid), 64'd1);
    endtask

    task automatic chk_coords(input string tag, input int base);
        chk({tag, "_npix"}, 64'(cx.size() - base), 64'd8);
        for (int i = 0; i < 8; i++) begin
            if (base + i < cx.size()) begin
                chk({tag, "_xy"}, 64'({cx[base+i], cy[base+i]}),
                    64'({16'(i % 4), 16'(i / 4)}));
            end
        end
    endtask

    task automatic chk_res(input string tag, input int base, input int n);
        chk({tag, "_nres"}, 64'(rid.size() - base), 64'(n));
        for (int k = 0; k < n; k++) begin
            if (base + k < rid.size()) begin
                chk({tag, "_res"},
                    64'({rid[base+k], rx[base+k], ry[base+k]}),
                    64'({8'(k + 1), ex(k + 1), ey(k + 1)}));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b_en;
        int b_c;
        int b_r;
        int b_d;
        int b_rv;
        int n;

        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ctl", 64'({busy, en, pix_ready, done, res_valid}), 64'd0);
        chk("rst_xy", 64'({x, y}), 64'd0);
        chk("rst_frame", 64'(frame), 64'd0);
        chk("rst_ids", 64'({obj_id, res_id}), 64'd0);
        chk("rst_res", 64'({res_x, res_y}), 64'd0);
        reset_n = 1'b1;

        // Frame with no labels: straight from flush to done
        width = 4; height = 2; num_labels = 0;
        pix_valid = 1'b1; res_ready = 1'b1;
        @(negedge clk);
        b_en = en_cnt; b_c = cx.size(); b_d = done_cnt; b_rv = rv_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("z_stream", 64'({busy, pix_ready, x, y}), 64'({2'b11, 32'd0}));
        wait_done("z_done", 100);
        @(negedge clk);
        chk("z_en", 64'(en_cnt - b_en), 64'd16);
        chk_coords("z", b_c);
        chk("z_rv", 64'(rv_cnt - b_rv), 64'd0);
        chk("z_gap", 64'(done_at - last_en), 64'd1);
        chk("z_frame", 64'(frame), 64'd1);
        chk("z_obj", 64'(obj_id), 64'd0);
        chk("z_ndone", 64'(done_cnt - b_d), 64'd1);
        chk("z_idle", 64'({busy, done}), 64'd0);

        // Unstalled frame with three labels
        num_labels = 3;
        b_en = en_cnt; b_c = cx.size(); b_r = rid.size(); b_d = done_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("a_done", 200);
        @(negedge clk);
        chk("a_en", 64'(en_cnt - b_en), 64'd16);
        chk_coords("a", b_c);
        chk_res("a", b_r, 3);
        if (hs_at.size() >= b_r + 3) begin
            chk("a_sp1", 64'(hs_at[b_r+1] - hs_at[b_r]), 64'(RL + 1));
            chk("a_sp2", 64'(hs_at[b_r+2] - hs_at[b_r+1]), 64'(RL + 1));
        end
        chk("a_frame", 64'(frame), 64'd2);
        chk("a_obj", 64'(obj_id), 64'd3);
        chk("a_ndone", 64'(done_cnt - b_d), 64'd1);

        // Same frame with a 5-cycle stall after two pixels
        b_en = en_cnt; b_c = cx.size(); b_r = rid.size();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        pix_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("b_stall", 64'({en, x, y}), 64'({1'b0, 16'd2, 16'd0}));
            @(negedge clk);
        end
        pix_valid = 1'b1;
        wait_done("b_done", 200);
        @(negedge clk);
        chk("b_en", 64'(en_cnt - b_en), 64'd16);
        chk_coords("b", b_c);
        chk_res("b", b_r, 3);
        chk("b_frame", 64'(frame), 64'd3);

        // Backpressure on id 2
        res_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_rv("c_rv1", 200);
        chk("c_id1", 64'(res_id), 64'd1);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        wait_rv("c_rv2", 20);
        for (int i = 0; i < 10; i++) begin
            chk("c_hold", 64'({res_valid, res_id, res_x, res_y}),
                64'({1'b1, 8'd2, ex(2), ey(2)}));
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        n = 1;
        while (!res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("c_space", 64'(n), 64'(RL + 1));
        chk("c_id3", 64'({res_id, res_x, res_y}), 64'({8'd3, ex(3), ey(3)}));
        res_ready = 1'b1;
        wait_done("c_done", 20);
        @(negedge clk);
        chk("c_frame", 64'(frame), 64'd4);

        // start during STREAM is ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("d_nostart", 64'({busy, x, y}), 64'({1'b1, 16'd3, 16'd0}));
        wait_done("d_done", 200);
        @(negedge clk);
        chk("d_frame", 64'(frame), 64'd5);

        // Zero width: done next cycle, frame unchanged
        width = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("w0_done", 64'({done, busy}), 64'b11);
        chk("w0_frame", 64'(frame), 64'd5);
        @(negedge clk);
        chk("w0_idle", 64'({done, busy}), 64'd0);

        // Reset while emitting id 2
        width = 4;
        res_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_rv("r_rv1", 200);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        wait_rv("r_rv2", 20);
        chk("r_id2", 64'(res_id), 64'd2);
        b_d = done_cnt;
        reset_n = 1'b0;
        #1;
        chk("r_ctl", 64'({busy, en, pix_ready, done, res_valid}), 64'd0);
        chk("r_xyf", 64'({x, y, frame}), 64'd0);
        chk("r_ids", 64'({obj_id, res_id}), 64'd0);
        chk("r_res", 64'({res_x, res_y}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        chk("r_nodone", 64'(done_cnt - b_d), 64'd0);
        reset_n = 1'b1;
        res_ready = 1'b1;
        @(negedge clk);
        b_en = en_cnt; b_c = cx.size(); b_r = rid.size();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("r_done", 200);
        @(negedge clk);
        chk("r_en", 64'(en_cnt - b_en), 64'd16);
        chk_coords("r", b_c);
        chk_res("r", b_r, 3);
        chk("r_frame", 64'(frame), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
